// File: rtl/isram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isram_pkg
// Description : Shared types and constants for the instruction-side memory
//               responder, and for the data-side responder to follow.
//               Holds the responder state encoding, the error response word,
//               the default fetch window, and the physical memory read
//               function (pmem_read).
// Revision    : 1.0 - initial release
// ============================================================================
package isram_pkg;

    // Responder state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } isram_state_e;

    // Data word returned with an access error.
    localparam logic [31:0] c_err_data = 32'h0000_0000;

    // Default legal fetch window.
    localparam logic [31:0] c_addr_base_default = 32'h8000_0000;
    localparam logic [31:0] c_addr_size_default = 32'h0800_0000;

    // Physical memory image as seen by the responders. The first words hold
    // the boot sequence; every other location returns a fixed scramble of its
    // own address.
    function automatic logic [31:0] pmem_read(input logic [31:0] addr);
        case (addr)
            32'h8000_0000: return 32'h0000_0413;
            32'h8000_0004: return 32'h0010_0073;
            32'h8000_0008: return 32'h0020_0093;
            default:       return addr ^ 32'h1357_9BDF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/isram_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : isram_lat_cnt
// Description : Loadable down-counter used to time memory response latency.
//               load has priority over en; en decrements and stops at zero.
//               done is high while the count is 1, i.e. during the final
//               cycle of the wait, so the edge that takes the count 1->0 is
//               also the edge on which the owner leaves its wait state.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous reset, active low
//               load     - load load_val into the counter
//               load_val - value to load
//               en       - decrement (saturates at zero)
//               done     - count equals 1
// Revision    : 1.0 - initial release
// ============================================================================
module isram_lat_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign done = (r_count == c_one);

endmodule
`default_nettype wire

// File: rtl/isram_resp.sv
`default_nettype none
// ============================================================================
// Module      : isram_resp
// Description : Instruction-memory responder. Accepts one fetch request at a
//               time, checks alignment and the legal address window, reads
//               the word through pmem_read, and presents the word (or an
//               error) LATENCY cycles after acceptance. The response is held
//               until the requester takes it.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous reset, active low
//               req_valid  - fetch request present
//               req_ready  - responder can accept a request this cycle
//               req_addr   - byte address of the instruction
//               resp_valid - response present
//               resp_ready - requester accepts the response
//               resp_data  - fetched word, zero on error
//               resp_err   - misaligned or out-of-window fetch
// Revision    : 1.0 - initial release
// ============================================================================
module isram_resp
    import isram_pkg::*;
#(
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] ADDR_BASE = c_addr_base_default,
    parameter logic [31:0] ADDR_SIZE = c_addr_size_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    if ((LATENCY == 0) || (LATENCY > 15)) begin : g_latency_check
        $error("isram_resp: LATENCY must be in 1..15");
    end

    localparam logic [3:0]  c_lat_load     = 4'(LATENCY - 1);
    localparam bit          c_single_cycle = (LATENCY == 1);
    // 33-bit window bounds so BASE+SIZE reaching 2^32 does not wrap to zero.
    localparam logic [32:0] c_win_lo       = {1'b0, ADDR_BASE};
    localparam logic [32:0] c_win_hi       = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

    isram_state_e r_state;
    isram_state_e w_next_state;

    logic        r_alive;
    logic        r_resp_err;
    logic [31:0] r_resp_data;
    logic        w_accept;
    logic        w_addr_ok;
    logic        w_cnt_load;
    logic        w_cnt_en;
    logic        w_cnt_done;

    // r_alive keeps req_ready low through reset and for the first cycle after
    // release; an IDLE state alone would advertise ready while still in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
        end
    end

    assign req_ready  = (r_state == IDLE) && r_alive;
    assign resp_valid = (r_state == RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign w_accept   = req_valid && req_ready;

    assign w_addr_ok = (req_addr[1:0] == 2'b00)
                    && ({1'b0, req_addr} >= c_win_lo)
                    && ({1'b0, req_addr} <  c_win_hi);

    isram_lat_cnt #(
        .WIDTH(4)
    ) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_cnt_load),
        .load_val (c_lat_load),
        .en       (w_cnt_en),
        .done     (w_cnt_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (c_single_cycle) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = WAIT;
                        w_cnt_load   = 1'b1;
                    end
                end
            end
            WAIT: begin
                w_cnt_en = 1'b1;
                if (w_cnt_done) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Response registers load only on acceptance, which happens only in
    // IDLE, so they stay stable through WAIT and RESP. Memory is read only
    // for legal addresses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else if (w_accept) begin
            if (w_addr_ok) begin
                r_resp_data <= pmem_read(req_addr);
                r_resp_err  <= 1'b0;
            end else begin
                r_resp_data <= c_err_data;
                r_resp_err  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_isram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_isram_resp
// Description : Self-checking bench for isram_resp. Runs one lane per
//               LATENCY value (1, 2, 3, 4, 15). Each lane has a
//               transaction-level reference model (accept cycle + latency
//               arithmetic, reference memory image) checked against the DUT
//               every cycle, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isram_resp;

    localparam int NL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NL-1:0] lane_done = '0;

    task automatic chk(input string what, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL lane%0d %s: actual %h required %h", lane, what, act, exp);
        end
    endtask

    // Reference physical memory image.
    function automatic logic [31:0] ref_mem(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0413;
            32'h8000_0004: return 32'h0010_0073;
            32'h8000_0008: return 32'h0020_0093;
            default:       return a ^ 32'h1357_9BDF;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la % 4 == 0) && (la >= 64'h8000_0000) && (la < 64'h8000_0000 + 64'h0800_0000);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1:    return 32'h8000_0000 + 4 * $urandom_range(0, 63);
            2:       return 32'h8000_0000 + $urandom_range(0, 255);
            3:       return 32'h7FFF_FFF0 + 4 * $urandom_range(0, 7);
            4:       return 32'h87FF_FFF0 + 4 * $urandom_range(0, 7);
            default: return $urandom();
        endcase
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 4 : 15;

        logic        reset_l    = 1'b1;
        logic        req_valid  = 1'b0;
        logic [31:0] req_addr   = '0;
        logic        resp_ready = 1'b0;
        logic        req_ready;
        logic        resp_valid;
        logic [31:0] resp_data;
        logic        resp_err;

        isram_resp #(
            .LATENCY(LAT)
        ) u_dut (
            .clk        (clk),
            .reset      (reset_l),
            .req_valid  (req_valid),
            .req_ready  (req_ready),
            .req_addr   (req_addr),
            .resp_valid (resp_valid),
            .resp_ready (resp_ready),
            .resp_data  (resp_data),
            .resp_err   (resp_err)
        );

        // Transaction-level model: a request is outstanding from its accept
        // edge until the handshake; the response is visible once LAT edges
        // have passed since acceptance.
        int unsigned cyc    = 0;
        bit          m_alive = 1'b0;
        bit          m_busy  = 1'b0;
        int unsigned m_acc   = 0;
        logic [31:0] m_data  = '0;
        logic        m_err   = 1'b0;

        always @(posedge clk) cyc <= cyc + 1;

        always @(posedge clk or negedge reset_l) begin
            if (!reset_l) begin
                m_alive <= 1'b0;
                m_busy  <= 1'b0;
            end else begin
                m_alive <= 1'b1;
                if (m_busy) begin
                    if ((cyc >= m_acc + LAT) && resp_ready) m_busy <= 1'b0;
                end else if (m_alive && req_valid) begin
                    m_busy <= 1'b1;
                    m_acc  <= cyc;
                    m_data <= ref_legal(req_addr) ? ref_mem(req_addr) : 32'h0;
                    m_err  <= !ref_legal(req_addr);
                end
            end
        end

        initial begin : p_compare
            bit exp_valid;
            forever begin
                @(posedge clk);
                #1;
                exp_valid = reset_l && m_busy && (cyc >= m_acc + LAT);
                chk("req_ready", g, 32'(req_ready), 32'(m_alive && !m_busy));
                chk("resp_valid", g, 32'(resp_valid), 32'(exp_valid));
                if (exp_valid) begin
                    chk("resp_data", g, resp_data, m_data);
                    chk("resp_err", g, 32'(resp_err), 32'(m_err));
                end
                if (!reset_l) begin
                    chk("reset_data", g, resp_data, 32'h0);
                    chk("reset_err", g, 32'(resp_err), 32'h0);
                end
            end
        end

        // Single directed fetch: wait for ready, accept, measure latency,
        // stall for 'stall' cycles, then hand shake.
        task automatic fetch(input logic [31:0] addr, input int stall,
                             input logic [31:0] exp_data, input logic exp_err);
            int n;
            req_valid  = 1'b1;
            req_addr   = addr;
            resp_ready = 1'b0;
            n = 0;
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("ready_wait", g, 32'(req_ready), 32'h1);
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = $urandom();
            n = 1;
            while (!resp_valid && n < 40) begin
                chk("busy_ready", g, 32'(req_ready), 32'h0);
                @(negedge clk);
                n++;
            end
            chk("latency", g, 32'(n), 32'(LAT));
            chk("lit_data", g, resp_data, exp_data);
            chk("lit_err", g, 32'(resp_err), 32'(exp_err));
            repeat (stall) begin
                @(negedge clk);
                chk("stall_valid", g, 32'(resp_valid), 32'h1);
                chk("stall_data", g, resp_data, exp_data);
                chk("stall_ready", g, 32'(req_ready), 32'h0);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            chk("post_hs_valid", g, 32'(resp_valid), 32'h0);
            chk("post_hs_ready", g, 32'(req_ready), 32'h1);
        endtask

        initial begin : p_stim
            int n;
            int k;
            int unsigned last;
            // Reset with a request pending.
            reset_l   = 1'b0;
            req_valid = 1'b1;
            req_addr  = 32'h8000_0000;
            repeat (3) @(negedge clk);
            chk("rst_ready", g, 32'(req_ready), 32'h0);
            chk("rst_valid", g, 32'(resp_valid), 32'h0);
            chk("rst_data", g, resp_data, 32'h0);
            reset_l   = 1'b1;
            req_valid = 1'b0;
            @(negedge clk);
            chk("rel_ready", g, 32'(req_ready), 32'h1);
            chk("rel_valid", g, 32'(resp_valid), 32'h0);

            fetch(32'h8000_0000, 0, 32'h0000_0413, 1'b0);
            fetch(32'h8000_0004, 6, 32'h0010_0073, 1'b0);
            fetch(32'h8000_0002, 0, 32'h0, 1'b1);
            fetch(32'h7FFF_FFFC, 0, 32'h0, 1'b1);
            fetch(32'h8800_0000, 2, 32'h0, 1'b1);
            fetch(32'h87FF_FFFC, 0, ref_mem(32'h87FF_FFFC), 1'b0);

            // Reset while the request is outstanding.
            req_valid = 1'b1;
            req_addr  = 32'h8000_0004;
            n = 0;
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            reset_l = 1'b0;
            #1;
            chk("midrst_valid", g, 32'(resp_valid), 32'h0);
            chk("midrst_ready", g, 32'(req_ready), 32'h0);
            chk("midrst_data", g, resp_data, 32'h0);
            repeat (2) @(negedge clk);
            reset_l = 1'b1;
            fetch(32'h8000_0008, 0, 32'h0020_0093, 1'b0);

            // Streaming with request held and response always taken.
            req_valid  = 1'b1;
            resp_ready = 1'b1;
            req_addr   = 32'h8000_0000;
            k = 0;
            n = 0;
            last = 0;
            while (k < 8 && n < 400) begin
                if (req_ready) begin
                    if (k > 0) chk("stream_spacing", g, cyc - last, 32'(LAT + 1));
                    last = cyc;
                    k++;
                    @(negedge clk);
                    req_addr = req_addr + 32'd4;
                end else begin
                    @(negedge clk);
                end
                n++;
            end
            req_valid = 1'b0;
            chk("stream_count", g, 32'(k), 32'd8);
            repeat (LAT + 3) @(negedge clk);

            // Random traffic with occasional resets.
            repeat (300) begin
                @(negedge clk);
                if ($urandom_range(0, 149) == 0) begin
                    reset_l = 1'b0;
                    @(negedge clk);
                    reset_l = 1'b1;
                end
                req_valid  = ($urandom_range(0, 1) == 1);
                req_addr   = rand_addr();
                resp_ready = ($urandom_range(0, 3) != 0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            repeat (LAT + 3) @(negedge clk);
            lane_done[g] = 1'b1;
        end
    end

    initial begin : p_main
        int w;
        w = 0;
        while (lane_done != {NL{1'b1}} && w < 20000) begin
            @(posedge clk);
            w++;
        end
        chk("lanes_done", 0, 32'(lane_done), 32'({NL{1'b1}}));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
